shift_right_iter: RTL and testbench

//  Multi-cycle right shifter. Accepts an N-bit word and a shift amount, then

---
 rtl/shift_pkg.sv | 14 +
 rtl/shiftRight.sv | 11 +
 rtl/shift_right_iter.sv | 83 ++++++++
 tb/tb_shift_right_iter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and helpers for the iterative right shifter.
package shift_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } shift_state_t;

   function automatic int amt_w(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/shiftRight.sv
// One-bit logical right shift stage; MSB fill is left to the caller.
module shiftRight #(
   parameter int N = 4
) (
   input  logic [N-1:0] data_in,
   output logic [N-1:0] data_out
);

   assign data_out = {1'b0, data_in[N-1:1]};

endmodule

// File: rtl/shift_right_iter.sv
// Multi-cycle right shifter: one bit per clock, start/busy/done handshake.
module shift_right_iter
   import shift_pkg::*;
#(
   parameter  int N     = 4,
   localparam int AMT_W = amt_w(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [N-1:0]     data_in,
   input  logic [AMT_W-1:0] amount,
   input  logic             arith,
   output logic             busy,
   output logic             done,
   output logic [N-1:0]     data_out
);

   localparam logic [AMT_W-1:0] CNT_MAX = AMT_W'(N);

   shift_state_t     state_q, state_d;
   logic [N-1:0]     work_q, work_d;
   logic [AMT_W-1:0] cnt_q, cnt_d;
   logic             fill_q, fill_d;
   logic [N-1:0]     data_out_q, data_out_d;
   logic [N-1:0]     next_w;
   logic [AMT_W-1:0] amt_clamp;

   shiftRight #(.N(N)) u_stage (
      .data_in  (work_q),
      .data_out (next_w)
   );

   assign amt_clamp = (amount >= CNT_MAX) ? CNT_MAX : amount;

   always_comb begin
      state_d    = state_q;
      work_d     = work_q;
      cnt_d      = cnt_q;
      fill_d     = fill_q;
      data_out_d = data_out_q;
      unique case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               work_d  = data_in;
               fill_d  = arith & data_in[N-1];
               cnt_d   = amt_clamp;
               state_d = (amt_clamp != '0) ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            work_d = {fill_q, next_w[N-2:0]};
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == AMT_W'(1)) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
      // Result is latched on the transition into DONE, including amount=0.
      if (state_d == DONE) data_out_d = work_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         work_q     <= '0;
         cnt_q      <= '0;
         fill_q     <= 1'b0;
         data_out_q <= '0;
      end else begin
         state_q    <= state_d;
         work_q     <= work_d;
         cnt_q      <= cnt_d;
         fill_q     <= fill_d;
         data_out_q <= data_out_d;
      end
   end

   assign busy     = (state_q == SHIFT);
   assign done     = (state_q == DONE);
   assign data_out = data_out_q;

endmodule

// File: tb/tb_shift_right_iter.sv
// Directed self-checking bench for shift_right_iter (N=4).
module tb_shift_right_iter;

   localparam int N = 4;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [N-1:0]  data_in = '0;
   logic [AW-1:0] amount = '0;
   logic          arith = 1'b0;
   logic          busy, done;
   logic [N-1:0]  data_out;

   int checks = 0;
   int failures = 0;

   shift_right_iter #(.N(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .data_in  (data_in),
      .amount   (amount),
      .arith    (arith),
      .busy     (busy),
      .done     (done),
      .data_out (data_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic st(input logic b, input logic d, input logic [N-1:0] q,
                     input string tag);
      chk({tag, ".busy"}, 32'(b), 32'(busy));
      chk({tag, ".done"}, 32'(d), 32'(done));
      chk({tag, ".dout"}, 32'(q), 32'(data_out));
   endtask

   task automatic go(input logic [N-1:0] d, input logic [AW-1:0] a,
                     input logic ar);
      start = 1'b1; data_in = d; amount = a; arith = ar;
   endtask

   initial begin
      // Asynchronous reset mid-cycle
      tick();
      #3 rst = 1'b1;
      #1;
      chk("rst.busy", 32'(busy), 32'(1'b0));
      chk("rst.done", 32'(done), 32'(1'b0));
      chk("rst.dout", 32'(data_out), 32'(4'b0000));
      tick();
      rst = 1'b0;
      tick();

      // 1011 >> 2 logical
      go(4'b1011, 3'd2, 1'b0);
      tick(); start = 1'b0;
      chk("t2.e0.busy", 32'(busy), 32'(1'b1));
      tick(); chk("t2.e1.busy", 32'(busy), 32'(1'b1));
      tick(); st(1'b0, 1'b1, 4'b0010, "t2.e2");
      tick(); st(1'b0, 1'b0, 4'b0010, "t2.e3");

      // 1000 >>> 3 arithmetic; operand change after accept ignored
      go(4'b1000, 3'd3, 1'b1);
      tick(); start = 1'b0; data_in = 4'b0001; arith = 1'b0;
      st(1'b1, 1'b0, 4'b0010, "t3.e0");
      tick(); tick();
      chk("t3.e2.done", 32'(done), 32'(1'b0));
      tick(); st(1'b0, 1'b1, 4'b1111, "t3.e3");

      // amount 0
      tick();
      go(4'b0110, 3'd0, 1'b0);
      tick(); start = 1'b0;
      st(1'b0, 1'b1, 4'b0110, "t4a.e0");

      // positive arithmetic: 0110 >>> 1 = 0011
      go(4'b0110, 3'd1, 1'b1);
      tick(); start = 1'b0;
      tick(); st(1'b0, 1'b1, 4'b0011, "tpa.e1");

      // amount 7 clamps to 4; start while busy ignored
      go(4'b1101, 3'd7, 1'b0);
      tick(); start = 1'b0;
      tick();
      go(4'b0001, 3'd1, 1'b0);
      tick(); start = 1'b0;
      chk("t5.e2.busy", 32'(busy), 32'(1'b1));
      tick();
      chk("t5.e3.done", 32'(done), 32'(1'b0));
      tick(); st(1'b0, 1'b1, 4'b0000, "t4b.e4");

      // back-to-back accept during DONE
      go(4'b0011, 3'd1, 1'b0);
      tick(); start = 1'b0;
      st(1'b1, 1'b0, 4'b0000, "t5b.e5");
      tick(); st(1'b0, 1'b1, 4'b0001, "t5b.e6");

      // arithmetic clamp: 1010 amount 5 -> 1111
      go(4'b1010, 3'd5, 1'b1);
      tick(); start = 1'b0;
      tick(); tick(); tick();
      chk("tac.e3.done", 32'(done), 32'(1'b0));
      tick(); st(1'b0, 1'b1, 4'b1111, "tac.e4");

      // reset mid-SHIFT aborts
      go(4'b1111, 3'd4, 1'b0);
      tick(); start = 1'b0;
      tick();
      #3 rst = 1'b1;
      #1;
      st(1'b0, 1'b0, 4'b0000, "t6.rst");
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t6.nodone", 32'(done), 32'(1'b0));
      end
      chk("t6.dout", 32'(data_out), 32'(4'b0000));

      // normal operation after reset release: 1001 >>> 1 = 1100
      go(4'b1001, 3'd1, 1'b1);
      tick(); start = 1'b0;
      chk("t6b.e0.busy", 32'(busy), 32'(1'b1));
      tick(); st(1'b0, 1'b1, 4'b1100, "t6b.e1");
      tick(); chk("t6b.e2.done", 32'(done), 32'(1'b0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
